// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, ignored codes, key indices, receiver states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/ack bytes that carry no key meaning.
  localparam int unsigned PS2_N_IGNORE = 8;
  localparam logic [7:0] PS2_IGNORE [PS2_N_IGNORE] = '{
    8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
  };

  // Key indices ({extended, scan_code}) consumed by the mode selector.
  localparam logic [8:0] KEY_ESC = 9'h076;
  localparam logic [8:0] KEY_1   = 9'h016;
  localparam logic [8:0] KEY_KP1 = 9'h069;
  localparam logic [8:0] KEY_2   = 9'h01E;
  localparam logic [8:0] KEY_KP2 = 9'h072;
  localparam logic [8:0] KEY_S   = 9'h01B;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < PS2_N_IGNORE; i++) begin
      if (b == PS2_IGNORE[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizer, clock glitch filter, 11-bit frame FSM, timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN  < 2) ? 1 : $clog2(FILTER_LEN);
  localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          sync_clk;
  logic          sync_data;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [TW-1:0] tout_cnt;
  logic          tout;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  rx_state_t     state;
  rx_state_t     state_nxt;

  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign rx_byte   = shift;

  // Two-flop synchronizers; lines idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: accept a new ps2_clk level after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (sync_clk == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= sync_clk;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Falling edge is flagged in the same cycle the filtered level flips high->low.
  always_comb begin
    fall = clk_filt & ~sync_clk & (filt_cnt == FW'(FILTER_LEN - 1));
  end

  // Mid-frame watchdog: restarts on every falling edge, idle while waiting for a start bit.
  always_ff @(posedge clk) begin
    if (rst || state == RX_IDLE || fall) tout_cnt <= '0;
    else                                 tout_cnt <= tout_cnt + 1'b1;
  end

  always_comb begin
    tout = (state != RX_IDLE) && !fall && (tout_cnt == TW'(TIMEOUT_CYC - 1));
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nxt = state;
    if (tout) begin
      state_nxt = RX_IDLE;
    end else if (fall) begin
      unique case (state)
        RX_IDLE:   if (!sync_data) state_nxt = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        RX_PARITY: state_nxt = RX_STOP;
        RX_STOP:   state_nxt = RX_IDLE;
        default:   state_nxt = RX_IDLE;
      endcase
    end
  end

  // Frame FSM outputs: stop-bit and odd-parity check, timeout error.
  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == RX_STOP && fall) begin
      if (sync_data && (^{shift, par_bit})) byte_valid = 1'b1;
      else                                  frame_err  = 1'b1;
    end
    if (tout) frame_err = 1'b1;
  end

  // Data path: LSB-first shift register, bit counter, parity capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      unique case (state)
        RX_IDLE:   bit_cnt <= '0;
        RX_DATA: begin
          shift   <= {sync_data, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        RX_PARITY: par_bit <= sync_data;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder: prefix tracking and held-key bitmap over received PS/2 bytes.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic         frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_err;
  logic       ext;
  logic       brk;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  // Prefix flags, key bitmap and event strobes, updated in the cycle a byte completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      been_ready  <= 1'b0;
      frame_err   <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      been_ready <= 1'b0;
      frame_err  <= rx_err;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else if (!is_ignored(rx_byte)) begin
          key_down[{ext, rx_byte}] <= ~brk;
          last_change              <= {ext, rx_byte};
          been_ready               <= 1'b1;
          ext                      <= 1'b0;
          brk                      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

  localparam int unsigned TOUT = 300;
  localparam int HALF = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic         frame_err;

  int errors = 0;
  int checks = 0;
  int br_cnt = 0;
  int fe_cnt = 0;

  ps2_key_decoder #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (been_ready) br_cnt <= br_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends frame bits first..last; lat = posedges from the stop-bit fall to been_ready (-1 if none).
  task automatic send_bits(input logic [10:0] fr, input int first, input int last, output int lat);
    lat = -1;
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int c = 1; c <= HALF; c++) begin
          @(posedge clk); #1;
          if (been_ready && lat < 0) lat = c;
        end
        @(negedge clk);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    wait_cyc(3 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, output int lat);
    send_bits(make_frame(b, bad_par), 0, 10, lat);
  endtask

  initial begin
    logic [511:0] exp_keys;
    int lat;
    int br0;
    int fe0;
    exp_keys = '0;

    wait_cyc(5);
    @(posedge clk); #1;
    check("rst_key_down", key_down, '0);
    check("rst_last_change", 512'(last_change), '0);
    check("rst_been_ready", 512'(been_ready), '0);
    check("rst_frame_err", 512'(frame_err), '0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(10);

    // ESC make
    br0 = br_cnt;
    send_byte(8'h76, 1'b0, lat);
    exp_keys[9'h076] = 1'b1;
    check("esc_make_keys", key_down, exp_keys);
    check("esc_make_last", 512'(last_change), 512'(9'h076));
    check("esc_make_pulses", 512'(br_cnt - br0), 512'(1));
    check("esc_make_latency", 512'(lat), 512'(6));

    // ESC break: F0 76
    br0 = br_cnt;
    send_byte(8'hF0, 1'b0, lat);
    check("f0_no_pulse", 512'(br_cnt - br0), 512'(0));
    send_byte(8'h76, 1'b0, lat);
    exp_keys[9'h076] = 1'b0;
    check("esc_brk_keys", key_down, exp_keys);
    check("esc_brk_last", 512'(last_change), 512'(9'h076));
    check("esc_brk_pulses", 512'(br_cnt - br0), 512'(1));

    // Extended up-arrow make: E0 75
    br0 = br_cnt;
    send_byte(8'hE0, 1'b0, lat);
    send_byte(8'h75, 1'b0, lat);
    exp_keys[9'h175] = 1'b1;
    check("up_make_keys", key_down, exp_keys);
    check("up_make_kp8", 512'(key_down[9'h075]), '0);
    check("up_make_last", 512'(last_change), 512'(9'h175));
    check("up_make_pulses", 512'(br_cnt - br0), 512'(1));

    // Extended up-arrow break: E0 F0 75
    br0 = br_cnt;
    send_byte(8'hE0, 1'b0, lat);
    send_byte(8'hF0, 1'b0, lat);
    send_byte(8'h75, 1'b0, lat);
    exp_keys[9'h175] = 1'b0;
    check("up_brk_keys", key_down, exp_keys);
    check("up_brk_kp8", 512'(key_down[9'h075]), '0);
    check("up_brk_last", 512'(last_change), 512'(9'h175));
    check("up_brk_pulses", 512'(br_cnt - br0), 512'(1));

    // Parity error on 0x16, then a clean 0x16
    br0 = br_cnt;
    fe0 = fe_cnt;
    send_byte(8'h16, 1'b1, lat);
    check("par_err_pulses", 512'(fe_cnt - fe0), 512'(1));
    check("par_err_no_ready", 512'(br_cnt - br0), 512'(0));
    check("par_err_keys", key_down, exp_keys);
    send_byte(8'h16, 1'b0, lat);
    exp_keys[9'h016] = 1'b1;
    check("key1_keys", key_down, exp_keys);
    check("key1_last", 512'(last_change), 512'(9'h016));

    // Typematic repeat of a held key
    br0 = br_cnt;
    send_byte(8'h16, 1'b0, lat);
    check("repeat_pulses", 512'(br_cnt - br0), 512'(1));
    check("repeat_keys", key_down, exp_keys);

    // Timeout after start + 4 data bits, then a clean 0x1B
    br0 = br_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(8'h1B, 1'b0), 0, 4, lat);
    wait_cyc(TOUT + 100);
    check("tout_err_pulses", 512'(fe_cnt - fe0), 512'(1));
    check("tout_no_ready", 512'(br_cnt - br0), 512'(0));
    send_byte(8'h1B, 1'b0, lat);
    exp_keys[9'h01B] = 1'b1;
    check("s_keys", key_down, exp_keys);
    check("s_last", 512'(last_change), 512'(9'h01B));

    // Reset in the middle of a frame with keys held
    send_bits(make_frame(8'h76, 1'b0), 0, 2, lat);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_keys = '0;
    check("midrst_keys", key_down, exp_keys);
    check("midrst_last", 512'(last_change), '0);
    check("midrst_ready", 512'(been_ready), '0);
    @(negedge clk);
    rst = 1'b0;
    br0 = br_cnt;
    send_bits(make_frame(8'h76, 1'b0), 3, 10, lat);
    wait_cyc(TOUT + 100);
    check("midrst_tail_no_ready", 512'(br_cnt - br0), 512'(0));
    check("midrst_tail_keys", key_down, exp_keys);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly upstream of the mode/state selector in the LED-fan design.
- Receives raw PS/2 keyboard clock/data lines, deserializes 11-bit frames, and interprets scan-code set 2 make/break/extended prefixes.
- Produces a 512-bit held-key bitmap, the index of the last changed key, and a one-cycle `been_ready` strobe for each key event.
- Key index is {extended, scan_code}, 9 bits; e.g. ESC = 9'h076, keypad 1 = 9'h069, up-arrow = 9'h175.

Parameters:
FILTER_LEN, 4, consecutive identical synced samples required before ps2_clk level change is accepted (glitch filter)
TIMEOUT_CYC, 100000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous)
ps2_data  input  1  raw PS/2 data from keyboard (asynchronous)
key_down  output  512  bit i = 1 while key with index i is held
last_change  output  9  index of most recent make/break event
been_ready  output  1  one-cycle pulse when key_down/last_change updated
frame_err  output  1  one-cycle pulse on parity/stop/timeout error

Behaviour:
- Reset is synchronous, active-high, on clk, and has priority over all other logic. Reset values: key_down=0, last_change=0, been_ready=0, frame_err=0, ext/brk flags=0, receiver state IDLE, bit counter 0, timeout counter 0. A frame in progress when rst asserts is discarded.
- Input conditioning: 2-flop synchronizer on both lines. Filtered ps2_clk changes only after FILTER_LEN equal samples. A falling edge is filtered high->low; it is sampled from synced ps2_data in that cycle.
- Frame receiver FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on falling edge, if data=0 go DATA with count=0; if data=1 remain in IDLE (spurious edge, no error).
  - DATA: shift in LSB first; after 8th bit go PARITY.
  - PARITY: capture bit, go STOP.
  - STOP: require stop=1 and odd parity over data+parity bit. On success emit the byte (internal byte_valid pulse); otherwise pulse frame_err. Return to IDLE either way.
  - Timeout: counter resets on each falling edge and runs in any state except IDLE. Reaching TIMEOUT_CYC returns to IDLE, pulses frame_err, and clears ext/brk.
  - Any frame error also clears ext/brk.
- Decoder, on byte_valid (same cycle):
  - 0xE0: set ext.
  - 0xF0: set brk. Prefix order E0 F0 and F0 E0 both accepted.
  - 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF: ignored, flags unchanged, no strobe. Pause sequence therefore decodes as ordinary codes; this is an accepted limitation.
  - Any other byte b: idx={ext,b}; key_down[idx]<=~brk; last_change<=idx; been_ready<=1; ext,brk<=0.
- Latency: stop-bit falling edge detected in cycle N -> key_down/last_change/been_ready visible in cycle N+1. been_ready is high exactly one cycle.
- Typematic repeat of a held key: been_ready re-pulses each repeat and key_down stays 1.
- Break of a key not held: bit stays 0, been_ready still pulses.
- Only one byte completes per frame, so events cannot coincide. frame_err and been_ready are never high in the same cycle.
- Outputs are registered; no combinational path from ps2 pins to outputs.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, the ignore-byte list;
  - key index constants used downstream (KEY_ESC=9'h076, KEY_1=9'h016, KEY_KP1=9'h069, KEY_2=9'h01E, KEY_KP2=9'h072, KEY_S=9'h01B);
  - receiver state encoding.
- Sub-module ps2_frame_rx: synchronizer, filter, frame FSM, and timeout. It outputs byte, byte_valid, and frame_err.
- ps2_key_decoder instantiates ps2_frame_rx and contains the prefix/bitmap logic.

Test Plan:
- Frame 0x76 (start 0, bits 0,1,1,0,1,1,1,0, parity 0, stop 1) -> key_down[9'h076]=1, last_change=9'h076, single been_ready pulse one cycle after the stop edge.
- Frames F0,76 after the above -> key_down[9'h076]=0, last_change=9'h076, exactly one been_ready pulse (none for F0).
- Frames E0,75 then E0,F0,75 -> key_down[9'h175] goes 1 then 0; key_down[9'h075] stays 0 throughout.
- Frame 0x16 with parity bit flipped -> frame_err pulse, no been_ready, key_down unchanged; next valid 0x16 -> key_down[9'h016]=1.
- Stall ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, return to IDLE; following valid 0x1B frame decodes to key_down[9'h01B]=1.
- Assert rst mid-frame with keys held -> all outputs 0 next cycle; remaining bits of the interrupted frame produce no event.
